turf_udp_timeclient: RTL and testbench
======================================

Name: turf_udp_timeclient

Overview:
- UDP time client: the initiator end of the TURF UDP time-service protocol.
- Sends a request datagram to a configured timeserver IP/port and waits for the PPS-aligned reply.
- Decodes the 4-byte network-order seconds count, presents it with a one-cycle valid strobe, and reports timeouts/bad replies.
- Sits on the UDP stack's per-port header/data AXI4-Stream pair, in the aclk domain.

Parameters:
- TIMEOUT_CYCLES, 32'd250_000_000: cycles in WAIT_HDR before the request is abandoned.
- AUTO_PERIOD, 32'd125_000_000: cycles between automatic requests (only with the macro).

Ports:
- aclk  in  1  stream/system clock.
- aresetn  in  1  asynchronous active-low reset.
- m_udphdr_tdata  out  64  request header {ip[63:32], port[31:16], length[15:0]}.
- m_udphdr_tvalid/tready  out/in  1  header handshake.
- m_udpdata_tdata  out  64  request payload.
- m_udpdata_tkeep  out  8  payload byte enables.
- m_udpdata_tlast  out  1  end of payload.
- m_udpdata_tvalid/tready  out/in  1  payload handshake.
- s_udphdr_tdata  in  64  reply header, same field layout.
- s_udphdr_tvalid/tready  in/out  1  reply header handshake.
- s_udpdata_tdata  in  64  reply payload.
- s_udpdata_tkeep  in  8  reply byte enables.
- s_udpdata_tlast  in  1  end of reply payload.
- s_udpdata_tvalid/tready  in/out  1  reply payload handshake.
- server_ip_i  in  32  timeserver IP; quasi-static.
- server_port_i  in  16  timeserver port; quasi-static.
- req_i  in  1  single-cycle request pulse.
- sec_o  out  32  last decoded seconds (host order).
- sec_valid_o  out  1  one-cycle strobe when sec_o updates.
- timeout_o  out  1  one-cycle strobe on timeout.
- busy_o  out  1  high whenever state != IDLE.
- bad_count_o  out  16  saturating count of rejected replies.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all tvalid=0; sec_o=0; sec_valid_o=0; timeout_o=0; busy_o=0; bad_count_o=0; seq=0; timer=0.
- s_udphdr_tready = s_udpdata_tready = 1 always. Every inbound datagram is consumed; those not expected are dropped.
- Request header: {server_ip_i, server_port_i, 16'd4}, driven from a register latched on leaving IDLE.
- Request payload: one beat; tdata = {32'h0, seq byte-swapped}; tkeep = 8'h0F; tlast = 1. seq increments after each request is sent.
- States:
  - IDLE: on req_i, latch server IP/port -> SEND_HDR.
  - SEND_HDR: m_udphdr_tvalid=1; on handshake -> SEND_DATA.
  - SEND_DATA: m_udpdata_tvalid=1; on handshake -> WAIT_HDR and clear timer.
  - WAIT_HDR: timer increments. On an s_udphdr beat whose ip/port equal the latched server values and whose length==4 -> WAIT_DATA. On a non-matching header -> DRAIN. When timer==TIMEOUT_CYCLES-1 with no header that cycle: pulse timeout_o -> IDLE.
  - WAIT_DATA: on s_udpdata beat with tlast=1 and tkeep[3:0]==4'hF: sec_o <= {d[7:0],d[15:8],d[23:16],d[31:24]}; sec_valid_o pulses the next cycle; -> IDLE. A beat with tlast=0 or a bad tkeep is rejected: bad_count_o++ (saturating at 16'hFFFF); -> DRAIN, or -> WAIT_HDR if that beat had tlast=1.
  - DRAIN: discard data beats until tlast; -> WAIT_HDR. The timer keeps running in DRAIN; a timeout in DRAIN aborts to IDLE after tlast.
- A non-matching header in WAIT_HDR counts as bad only if its ip equals the server IP.
- Header arriving in the same cycle as timer expiry: the header wins; no timeout.
- req_i while busy_o=1 is ignored; requests are not queued.
- Backpressure: tvalid holds and tdata is stable until tready.
- Reset mid-transaction drops any in-flight stream output immediately. The downstream UDP stack is reset by the same aresetn.
- Latency: reply tlast beat to sec_valid_o = 1 cycle.

Optional Feature:
- Macro TIMECLIENT_AUTOREQ_EN.
- Defined: a free-running counter generates an internal request every AUTO_PERIOD cycles, ORed with req_i. A pending auto tick while busy is dropped, not deferred.
- Undefined: requests come only from req_i; AUTO_PERIOD is unused.

Decomposition:
- Shared package turf_udp_pkg:
  - UDP header field offsets (IP 63:32, port 31:16, length 15:0).
  - TIMESERVER_PAYLOAD_LEN = 4.
  - Byte-swap function for 32-bit network order.
- Timeserver and client both import it.
- One natural sub-module, udp_hdr_match: compares header ip/port/length against expected values, registered match/len_ok outputs.

Test Plan:
- server 10.0.0.1:5000, req_i pulse, tready=1 -> m_udphdr_tdata=64'h0A000001_1388_0004; one data beat with tkeep 8'h0F, tlast=1.
- Reply header 0A000001_1388_0004 then data 32'h78563412 (tlast=1, tkeep=8'h0F) -> sec_o=32'h12345678 with a 1-cycle sec_valid_o.
- No reply, TIMEOUT_CYCLES=100 -> timeout_o pulses 100 cycles after the data handshake; busy_o falls; sec_valid_o is never asserted.
- Reply from port 5001 (same IP), 2-beat payload -> both beats drained; bad_count_o=1; a subsequent correct reply is still accepted.
- m_udphdr_tready held low 20 cycles, req_i pulsed again meanwhile, aresetn dropped mid-SEND_DATA -> tdata stable while held; second req ignored; after reset all tvalid=0, state IDLE.
- TIMECLIENT_AUTOREQ_EN, AUTO_PERIOD=50, instant replies -> a request header every 50 cycles; the seq field increments 0,1,2.

Source files
------------

// File: rtl/turf_udp_pkg.sv
// rtl/turf_udp_pkg.sv - shared UDP header field layout, timeserver constants and byte-swap helper
package turf_udp_pkg;

    localparam int HDR_IP_LSB   = 32;
    localparam int HDR_PORT_LSB = 16;
    localparam int HDR_LEN_LSB  = 0;

    localparam logic [15:0] TIMESERVER_PAYLOAD_LEN = 16'd4;

    typedef enum logic [2:0] {
        TC_IDLE,
        TC_SEND_HDR,
        TC_SEND_DATA,
        TC_WAIT_HDR,
        TC_WAIT_DATA,
        TC_DRAIN
    } tc_state_t;

    function automatic logic [31:0] hdr_ip(input logic [63:0] h);
        return h[HDR_IP_LSB +: 32];
    endfunction

    function automatic logic [15:0] hdr_port(input logic [63:0] h);
        return h[HDR_PORT_LSB +: 16];
    endfunction

    function automatic logic [15:0] hdr_len(input logic [63:0] h);
        return h[HDR_LEN_LSB +: 16];
    endfunction

    // Network order <-> host order for a 32-bit word.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/udp_hdr_match.sv
// rtl/udp_hdr_match.sv - registered compare of a UDP header beat against expected ip/port/length
module udp_hdr_match
    import turf_udp_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        hdr_tvalid,
    input  logic [63:0] hdr_tdata,
    input  logic [31:0] exp_ip,
    input  logic [15:0] exp_port,
    input  logic [15:0] exp_len,
    output logic        hit,
    output logic        match,
    output logic        ip_ok,
    output logic        len_ok
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hit    <= 1'b0;
            match  <= 1'b0;
            ip_ok  <= 1'b0;
            len_ok <= 1'b0;
        end else begin
            hit    <= hdr_tvalid;
            match  <= (hdr_ip(hdr_tdata) == exp_ip) && (hdr_port(hdr_tdata) == exp_port);
            ip_ok  <= (hdr_ip(hdr_tdata) == exp_ip);
            len_ok <= (hdr_len(hdr_tdata) == exp_len);
        end
    end

endmodule

// File: rtl/turf_udp_timeclient.sv
// rtl/turf_udp_timeclient.sv - TURF UDP time-service client; TIMECLIENT_AUTOREQ_EN enables periodic requests
module turf_udp_timeclient
    import turf_udp_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
    parameter logic [31:0] AUTO_PERIOD    = 32'd125_000_000
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,
    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,
    input  logic [63:0] s_udphdr_tdata,
    input  logic        s_udphdr_tvalid,
    output logic        s_udphdr_tready,
    input  logic [63:0] s_udpdata_tdata,
    input  logic [7:0]  s_udpdata_tkeep,
    input  logic        s_udpdata_tlast,
    input  logic        s_udpdata_tvalid,
    output logic        s_udpdata_tready,
    input  logic [31:0] server_ip_i,
    input  logic [15:0] server_port_i,
    input  logic        req_i,
    output logic [31:0] sec_o,
    output logic        sec_valid_o,
    output logic        timeout_o,
    output logic        busy_o,
    output logic [15:0] bad_count_o
);

    tc_state_t   state, state_n;
    logic [31:0] srv_ip, seq, timer;
    logic [15:0] srv_port;
    logic        req_any, expired, decide, hdr_ok, hdr_en;
    logic        latch_srv, seq_inc, timer_clr, sec_load, bad_inc, timeout_set;
    logic        hit_q, match_q, ip_ok_q, len_ok_q;
    logic        unused_ok;

`ifdef TIMECLIENT_AUTOREQ_EN
    logic [31:0] auto_cnt;
    logic        auto_tick;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            auto_cnt <= '0;
        else if (auto_tick)
            auto_cnt <= '0;
        else
            auto_cnt <= auto_cnt + 32'd1;
    end

    // Ticks landing while busy are simply lost; IDLE is the only state that listens.
    assign auto_tick = (auto_cnt == AUTO_PERIOD - 32'd1);
    assign req_any   = req_i | auto_tick;
`else
    logic unused_auto;
    assign unused_auto = ^AUTO_PERIOD;
    assign req_any     = req_i;
`endif

    assign s_udphdr_tready  = 1'b1;
    assign s_udpdata_tready = 1'b1;
    assign busy_o           = (state != TC_IDLE);
    assign m_udphdr_tvalid  = (state == TC_SEND_HDR);
    assign m_udphdr_tdata   = {srv_ip, srv_port, TIMESERVER_PAYLOAD_LEN};
    assign m_udpdata_tvalid = (state == TC_SEND_DATA);
    assign m_udpdata_tdata  = {32'h0, bswap32(seq)};
    assign m_udpdata_tkeep  = 8'h0F;
    assign m_udpdata_tlast  = 1'b1;
    assign unused_ok        = ^{s_udpdata_tdata[63:32], s_udpdata_tkeep[7:4]};

    // The header compare is registered, so WAIT_HDR decides one cycle after the beat;
    // a data beat in that decision cycle is handled as if already in the target state.
    assign hdr_en  = s_udphdr_tvalid && (state == TC_WAIT_HDR) && !hit_q;
    assign decide  = (state == TC_WAIT_HDR) && hit_q;
    assign hdr_ok  = match_q && len_ok_q;
    assign expired = (timer >= TIMEOUT_CYCLES - 32'd1);

    udp_hdr_match u_hdr_match (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .hdr_tvalid (hdr_en),
        .hdr_tdata  (s_udphdr_tdata),
        .exp_ip     (srv_ip),
        .exp_port   (srv_port),
        .exp_len    (TIMESERVER_PAYLOAD_LEN),
        .hit        (hit_q),
        .match      (match_q),
        .ip_ok      (ip_ok_q),
        .len_ok     (len_ok_q)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= TC_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        latch_srv   = 1'b0;
        seq_inc     = 1'b0;
        timer_clr   = 1'b0;
        sec_load    = 1'b0;
        bad_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            TC_IDLE: if (req_any) begin
                latch_srv = 1'b1;
                state_n   = TC_SEND_HDR;
            end
            TC_SEND_HDR: if (m_udphdr_tready) state_n = TC_SEND_DATA;
            TC_SEND_DATA: if (m_udpdata_tready) begin
                state_n   = TC_WAIT_HDR;
                timer_clr = 1'b1;
                seq_inc   = 1'b1;
            end
            TC_WAIT_HDR: begin
                if (decide) begin
                    state_n = hdr_ok ? TC_WAIT_DATA : TC_DRAIN;
                    bad_inc = !hdr_ok && ip_ok_q;
                end else if (!s_udphdr_tvalid && expired) begin
                    state_n     = TC_IDLE;
                    timeout_set = 1'b1;
                end
            end
            default: ;
        endcase
        if (s_udpdata_tvalid) begin
            if (state == TC_WAIT_DATA || (decide && hdr_ok)) begin
                if (s_udpdata_tlast && s_udpdata_tkeep[3:0] == 4'hF) begin
                    sec_load = 1'b1;
                    state_n  = TC_IDLE;
                end else begin
                    bad_inc = 1'b1;
                    state_n = s_udpdata_tlast ? TC_WAIT_HDR : TC_DRAIN;
                end
            end else if ((state == TC_DRAIN || (decide && !hdr_ok)) && s_udpdata_tlast) begin
                state_n     = expired ? TC_IDLE : TC_WAIT_HDR;
                timeout_set = expired;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            srv_ip      <= '0;
            srv_port    <= '0;
            seq         <= '0;
            timer       <= '0;
            sec_o       <= '0;
            sec_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
            bad_count_o <= '0;
        end else begin
            if (latch_srv) begin
                srv_ip   <= server_ip_i;
                srv_port <= server_port_i;
            end
            if (seq_inc)
                seq <= seq + 32'd1;
            if (timer_clr)
                timer <= '0;
            else if (state inside {TC_WAIT_HDR, TC_WAIT_DATA, TC_DRAIN} && timer != 32'hFFFF_FFFF)
                timer <= timer + 32'd1;
            if (sec_load)
                sec_o <= bswap32(s_udpdata_tdata[31:0]);
            sec_valid_o <= sec_load;
            timeout_o   <= timeout_set;
            if (bad_inc && bad_count_o != 16'hFFFF)
                bad_count_o <= bad_count_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_turf_udp_timeclient.sv
// tb/tb_turf_udp_timeclient.sv - scoreboard bench for turf_udp_timeclient with a randomized reply mix
module tb_turf_udp_timeclient;

    localparam logic [31:0] TO = 32'd100;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] m_udphdr_tdata, m_udpdata_tdata, s_udphdr_tdata, s_udpdata_tdata;
    logic        m_udphdr_tvalid, m_udphdr_tready, m_udpdata_tvalid, m_udpdata_tready;
    logic [7:0]  m_udpdata_tkeep, s_udpdata_tkeep;
    logic        m_udpdata_tlast, s_udpdata_tlast;
    logic        s_udphdr_tvalid, s_udphdr_tready, s_udpdata_tvalid, s_udpdata_tready;
    logic [31:0] server_ip_i, sec_o;
    logic [15:0] server_port_i, bad_count_o;
    logic        req_i, sec_valid_o, timeout_o, busy_o;

    always #5 aclk = ~aclk;

    turf_udp_timeclient #(.TIMEOUT_CYCLES(TO), .AUTO_PERIOD(32'd50)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid), .m_udphdr_tready(m_udphdr_tready),
        .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep), .m_udpdata_tlast(m_udpdata_tlast),
        .m_udpdata_tvalid(m_udpdata_tvalid), .m_udpdata_tready(m_udpdata_tready),
        .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
        .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep), .s_udpdata_tlast(s_udpdata_tlast),
        .s_udpdata_tvalid(s_udpdata_tvalid), .s_udpdata_tready(s_udpdata_tready),
        .server_ip_i(server_ip_i), .server_port_i(server_port_i), .req_i(req_i),
        .sec_o(sec_o), .sec_valid_o(sec_valid_o), .timeout_o(timeout_o), .busy_o(busy_o),
        .bad_count_o(bad_count_o)
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_hdr[$];
    logic [63:0] exp_pay[$];
    logic [31:0] exp_sec[$];
    int          exp_to = 0;
    logic [31:0] seq_m = 0;
    int          bad_m = 0;
    bit          rand_bp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference byte reversal: byte i of the wire word lands in byte 3-i of the host word.
    function automatic logic [31:0] net_to_host(input logic [31:0] d);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++)
            r = r + (((d >> (8 * i)) & 32'hFF) << (8 * (3 - i)));
        return r;
    endfunction

    // Monitor / scoreboard: compares whatever the DUT presents against the queued expectations.
    logic        hdr_stall = 0, dat_stall = 0;
    logic [63:0] hdr_prev, dat_prev;
    always @(negedge aclk) begin
        if (!aresetn) begin
            hdr_stall = 0;
            dat_stall = 0;
        end else begin
            if (hdr_stall) begin
                check("hdr_hold_valid", m_udphdr_tvalid, 1);
                check("hdr_hold_data", m_udphdr_tdata, hdr_prev);
            end
            if (dat_stall) begin
                check("data_hold_valid", m_udpdata_tvalid, 1);
                check("data_hold_data", m_udpdata_tdata, dat_prev);
            end
            hdr_stall = m_udphdr_tvalid && !m_udphdr_tready;
            hdr_prev  = m_udphdr_tdata;
            dat_stall = m_udpdata_tvalid && !m_udpdata_tready;
            dat_prev  = m_udpdata_tdata;
            if (m_udphdr_tvalid && m_udphdr_tready) begin
                if (exp_hdr.size() == 0) check("hdr_unexpected", 1, 0);
                else check("req_hdr", m_udphdr_tdata, exp_hdr.pop_front());
            end
            if (m_udpdata_tvalid && m_udpdata_tready) begin
                if (exp_pay.size() == 0) check("pay_unexpected", 1, 0);
                else check("req_pay", m_udpdata_tdata, exp_pay.pop_front());
                check("req_keep_last", {m_udpdata_tkeep, 7'h0, m_udpdata_tlast}, {8'h0F, 7'h0, 1'b1});
            end
            if (sec_valid_o) begin
                if (exp_sec.size() == 0) check("sec_unexpected", 1, 0);
                else check("sec_value", sec_o, exp_sec.pop_front());
            end
            if (timeout_o) begin
                check("timeout_expected", exp_to > 0, 1);
                if (exp_to > 0) exp_to--;
            end
        end
    end

    always @(posedge aclk) begin
        if (rand_bp) begin
            #1;
            m_udphdr_tready  = ($urandom_range(0, 3) != 0);
            m_udpdata_tready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic issue_req(input logic [31:0] ip, input logic [15:0] port);
        server_ip_i   = ip;
        server_port_i = port;
        exp_hdr.push_back({ip, port, 16'd4});
        exp_pay.push_back({32'h0, net_to_host(seq_m)});
        seq_m++;
        req_i = 1;
        idle(1);
        req_i = 0;
    endtask

    task automatic wait_data_hs();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (m_udpdata_tvalid && m_udpdata_tready) done = 1;
        end
        check("data_handshake_seen", done, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge aclk);
            if (!busy_o) done = 1;
        end
        check("idle_reached", done, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic send_hdr(input logic [63:0] h);
        s_udphdr_tdata  = h;
        s_udphdr_tvalid = 1;
        idle(1);
        s_udphdr_tvalid = 0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_udpdata_tdata  = d;
        s_udpdata_tkeep  = k;
        s_udpdata_tlast  = l;
        s_udpdata_tvalid = 1;
        idle(1);
        s_udpdata_tvalid = 0;
        s_udpdata_tlast  = 0;
    endtask

    task automatic good_reply(input logic [31:0] ip, input logic [15:0] port, input logic [31:0] d);
        send_hdr({ip, port, 16'd4});
        idle($urandom_range(0, 2));
        exp_sec.push_back(net_to_host(d));
        send_beat({$urandom, d}, 8'h0F, 1);
        check("sec_latency", sec_valid_o, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [31:0] ip, d;
        logic [15:0] port;
        int kind, nb;
        m_udphdr_tready = 1; m_udpdata_tready = 1;
        s_udphdr_tdata = 0; s_udphdr_tvalid = 0;
        s_udpdata_tdata = 0; s_udpdata_tkeep = 0; s_udpdata_tlast = 0; s_udpdata_tvalid = 0;
        server_ip_i = 0; server_port_i = 0; req_i = 0;

        #12;
        check("rst_hdr_tvalid", m_udphdr_tvalid, 0);
        check("rst_data_tvalid", m_udpdata_tvalid, 0);
        check("rst_sec", sec_o, 0);
        check("rst_flags", {sec_valid_o, timeout_o, busy_o}, 0);
        check("rst_bad", bad_count_o, 0);
        check("rst_treadys", {s_udphdr_tready, s_udpdata_tready}, 2'b11);
        @(posedge aclk); #1;
        aresetn = 1;
        idle(2);

        // Known-answer exchange with 10.0.0.1:5000.
        issue_req(32'h0A00_0001, 16'd5000);
        check("req_hdr_literal", {server_ip_i, server_port_i, 16'd4}, 64'h0A000001_1388_0004);
        wait_data_hs();
        idle(2);
        send_hdr(64'h0A000001_1388_0004);
        exp_sec.push_back(32'h1234_5678);
        send_beat(64'h0000_0000_7856_3412, 8'h0F, 1);
        check("sec_latency", sec_valid_o, 1);
        wait_idle();
        check("sec_hold", sec_o, 32'h1234_5678);

        // No reply: timeout exactly TO cycles after the data handshake.
        issue_req(32'h0A00_0001, 16'd5000);
        exp_to++;
        wait_data_hs();
        repeat (TO - 1) @(posedge aclk);
        @(negedge aclk);
        check("timeout_early", {timeout_o, busy_o}, 2'b01);
        @(posedge aclk);
        @(negedge aclk);
        check("timeout_pulse", {timeout_o, busy_o, sec_valid_o}, 3'b100);
        @(posedge aclk); #1;

        // Wrong port from the server IP, 2-beat payload, then a good reply.
        issue_req(32'h0A00_0001, 16'd5000);
        wait_data_hs();
        send_hdr(64'h0A000001_1389_0008);
        send_beat(64'h1111, 8'hFF, 0);
        send_beat(64'h2222, 8'hFF, 1);
        bad_m++;
        good_reply(32'h0A00_0001, 16'd5000, 32'hDDCC_BBAA);
        wait_idle();
        check("bad_after_port", bad_count_o, bad_m);

        // Randomized mix of reply faults, each followed by a valid reply.
        rand_bp = 1;
        for (int t = 0; t < 24; t++) begin
            ip   = $urandom;
            port = 16'($urandom);
            d    = $urandom;
            kind = $urandom_range(0, 4);
            nb   = $urandom_range(1, 3);
            issue_req(ip, port);
            wait_data_hs();
            idle($urandom_range(0, 3));
            case (kind)
                1: begin
                    if ($urandom_range(0, 1) == 1) send_hdr({ip, port + 16'd1, 16'd4});
                    else send_hdr({ip, port, 16'(8 * nb)});
                    for (int b = 0; b < nb; b++) send_beat({$urandom, $urandom}, 8'hFF, b == nb - 1);
                    bad_m++;
                end
                2: begin
                    send_hdr({ip + 32'd1 + 32'($urandom_range(0, 99)), port, 16'd4});
                    for (int b = 0; b < nb; b++) send_beat({$urandom, $urandom}, 8'hFF, b == nb - 1);
                end
                3: begin
                    send_hdr({ip, port, 16'd4});
                    send_beat({32'h0, $urandom}, {4'h0, 4'($urandom_range(0, 14))}, 1);
                    bad_m++;
                end
                4: begin
                    send_hdr({ip, port, 16'd4});
                    send_beat({32'h0, $urandom}, 8'h0F, 0);
                    send_beat({32'h0, $urandom}, 8'h0F, 1);
                    bad_m++;
                end
                default: ;
            endcase
            idle($urandom_range(0, 2));
            good_reply(ip, port, d);
            wait_idle();
            check("bad_count", bad_count_o, bad_m);
        end
        rand_bp = 0;
        idle(1);

        // Header backpressure, ignored second request, reset during SEND_DATA.
        m_udphdr_tready  = 0;
        m_udpdata_tready = 0;
        issue_req(32'hC0A8_0102, 16'd123);
        idle(9);
        req_i = 1; idle(1); req_i = 0;
        idle(10);
        check("hdr_held_valid", m_udphdr_tvalid, 1);
        m_udphdr_tready = 1;
        idle(1);
        m_udphdr_tready = 0;
        idle(5);
        check("data_held_valid", m_udpdata_tvalid, 1);
        @(negedge aclk);
        aresetn = 0;
        #1;
        check("rst_mid_tvalid", {m_udphdr_tvalid, m_udpdata_tvalid, busy_o}, 0);
        exp_pay.delete();
        seq_m = 0;
        bad_m = 0;
        @(posedge aclk); #1;
        aresetn = 1;
        m_udphdr_tready  = 1;
        m_udpdata_tready = 1;
        idle(5);
        check("post_rst_idle", {m_udphdr_tvalid, busy_o, bad_count_o}, 0);

        // Sequence restarts from zero after reset.
        issue_req(32'h0A00_0001, 16'd5000);
        wait_data_hs();
        good_reply(32'h0A00_0001, 16'd5000, 32'h0102_0304);
        wait_idle();
        idle(2);

        check("hdr_queue_empty", exp_hdr.size(), 0);
        check("pay_queue_empty", exp_pay.size(), 0);
        check("sec_queue_empty", exp_sec.size(), 0);
        check("timeout_queue_empty", exp_to, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
